// File: rtl/tlc_timed.sv
// tlc_timed: highway/country traffic light controller with configurable phase
// durations, all-red clearance, min/max country green and a latched
// pedestrian request. All durations are counted in clk cycles.
module tlc_timed #(
    parameter int TW       = 8,
    parameter int T_HW_MIN = 10,
    parameter int T_YEL    = 3,
    parameter int T_ALLRED = 1,
    parameter int T_CR_MIN = 5,
    parameter int T_CR_MAX = 20
) (
    input  logic          clk,
    input  logic          rst,               // asynchronous, active low
    input  logic          x,                 // country vehicle sensor
    input  logic          pb,                // pedestrian button
    output logic [1:0]    highway,           // 00 red, 01 yellow, 10 green
    output logic [1:0]    country,
    output logic          pedestrian_light,  // 1 = walk
    output logic          ped_req,
    output logic [2:0]    phase,
    output logic [TW-1:0] tmr
);

    typedef enum logic [2:0] {
        S_HG  = 3'd0,
        S_HY  = 3'd1,
        S_AR1 = 3'd2,
        S_CG  = 3'd3,
        S_CY  = 3'd4,
        S_AR2 = 3'd5
    } state_t;

    // Terminal timer values: a phase leaves on the edge where tmr equals
    // (duration - 1), so the phase is visible for exactly 'duration' cycles.
    localparam logic [TW-1:0] L_HW_LAST  = TW'(T_HW_MIN - 1);
    localparam logic [TW-1:0] L_YEL_LAST = TW'(T_YEL - 1);
    localparam logic [TW-1:0] L_AR_LAST  = TW'(T_ALLRED - 1);
    localparam logic [TW-1:0] L_CRN_LAST = TW'(T_CR_MIN - 1);
    localparam logic [TW-1:0] L_CRX_LAST = TW'(T_CR_MAX - 1);
    localparam logic [TW-1:0] L_TMR_MAX  = '1;

    state_t        r_state;
    state_t        w_next;
    logic [TW-1:0] r_tmr;
    logic          r_ped_req;
    logic          w_ar1_to_cg;

    // Next-state selection and Moore lamp decode.
    always_comb begin
        w_next           = r_state;
        highway          = 2'b00;
        country          = 2'b00;
        pedestrian_light = 1'b0;
        case (r_state)
            S_HG: begin
                highway = 2'b10;
                if ((r_tmr >= L_HW_LAST) && (x || r_ped_req)) w_next = S_HY;
            end
            S_HY: begin
                highway = 2'b01;
                if (r_tmr == L_YEL_LAST) w_next = S_AR1;
            end
            S_AR1: begin
                if (r_tmr == L_AR_LAST) w_next = S_CG;
            end
            S_CG: begin
                country          = 2'b10;
                pedestrian_light = 1'b1;
                if (((r_tmr >= L_CRN_LAST) && !x) || (r_tmr == L_CRX_LAST)) w_next = S_CY;
            end
            S_CY: begin
                country = 2'b01;
                if (r_tmr == L_YEL_LAST) w_next = S_AR2;
            end
            S_AR2: begin
                if (r_tmr == L_AR_LAST) w_next = S_HG;
            end
            // Illegal codes 6/7 recover to highway green; lamps stay all red.
            default: w_next = S_HG;
        endcase
    end

    assign w_ar1_to_cg = (r_state == S_AR1) && (w_next == S_CG);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_HG;
        else      r_state <= w_next;
    end

    // Phase timer: clears on every state change, otherwise saturating count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                    r_tmr <= '0;
        else if (w_next != r_state)  r_tmr <= '0;
        else if (r_tmr != L_TMR_MAX) r_tmr <= r_tmr + TW'(1);
    end

    // Pedestrian request latch: presses during walk are ignored, and entering
    // country green serves (clears) the request, winning over a same-edge press.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_ped_req <= 1'b0;
        else      r_ped_req <= (r_ped_req | (pb & (r_state != S_CG))) & ~w_ar1_to_cg;
    end

    assign phase   = r_state;
    assign tmr     = r_tmr;
    assign ped_req = r_ped_req;

endmodule

// File: tb/tb_tlc_timed.sv
// tb_tlc_timed: directed scenarios for tlc_timed with default parameters.
// The driver pushes the hand-derived state expected after each clock edge;
// a monitor pops and compares on the falling edge (or on an immediate
// strobe for asynchronous reset checks).
module tb_tlc_timed;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       x   = 1'b0;
    logic       pb  = 1'b0;
    logic [1:0] highway;
    logic [1:0] country;
    logic       pedestrian_light;
    logic       ped_req;
    logic [2:0] phase;
    logic [7:0] tmr;

    logic [16:0] exp_q[$];
    logic [16:0] got_w;
    logic [16:0] exp_w;
    logic        strobe = 1'b0;
    int          n_vec  = 0;
    int          n_err  = 0;

    tlc_timed dut (
        .clk              (clk),
        .rst              (rst),
        .x                (x),
        .pb               (pb),
        .highway          (highway),
        .country          (country),
        .pedestrian_light (pedestrian_light),
        .ped_req          (ped_req),
        .phase            (phase),
        .tmr              (tmr)
    );

    // Clock
    always #5 clk = ~clk;

    // Expected word: {phase, tmr, ped_req, highway, country, walk}.
    // Lamp values come straight from the per-state lamp table.
    function automatic logic [16:0] mk(input logic [2:0] ph, input logic [7:0] t, input logic pr);
        logic [1:0] hw;
        logic [1:0] cr;
        logic       pl;
        hw = 2'b00;
        cr = 2'b00;
        pl = 1'b0;
        case (ph)
            3'd0: hw = 2'b10;
            3'd1: hw = 2'b01;
            3'd3: begin cr = 2'b10; pl = 1'b1; end
            3'd4: cr = 2'b01;
            default: ;
        endcase
        return {ph, t, pr, hw, cr, pl};
    endfunction

    // Monitor / scoreboard
    always @(negedge clk or posedge strobe) begin
        if (exp_q.size() > 0) begin
            exp_w = exp_q.pop_front();
            got_w = {phase, tmr, ped_req, highway, country, pedestrian_light};
            n_vec++;
            if (got_w !== exp_w) begin
                n_err++;
                $display("FAIL vec%0d @%0t: got phase=%0d tmr=%0d ped_req=%b hw=%b cr=%b walk=%b, expected phase=%0d tmr=%0d ped_req=%b hw=%b cr=%b walk=%b",
                         n_vec, $time, got_w[16:14], got_w[13:6], got_w[5], got_w[4:3], got_w[2:1], got_w[0],
                         exp_w[16:14], exp_w[13:6], exp_w[5], exp_w[4:3], exp_w[2:1], exp_w[0]);
            end
        end
    end

    // One clock: inputs xv/pbv are sampled at the coming edge; the expected
    // state after that edge is queued.
    task automatic cyc(input logic xv, input logic pbv, input logic [2:0] ph, input int t, input logic pr);
        x  = xv;
        pb = pbv;
        @(posedge clk);
        #1;
        exp_q.push_back(mk(ph, t[7:0], pr));
    endtask

    // n cycles in one phase; tmr counts up from t0 when inc, else holds at t0.
    task automatic seg(input logic xv, input logic pbv, input logic [2:0] ph, input int n,
                       input int t0, input logic inc, input logic pr);
        for (int i = 0; i < n; i++) cyc(xv, pbv, ph, inc ? t0 + i : t0, pr);
    endtask

    // Pull reset low between edges and check outputs before any edge.
    task automatic async_reset();
        @(negedge clk);
        #1;
        rst = 1'b0;
        x   = 1'b0;
        pb  = 1'b0;
        exp_q.push_back(mk(3'd0, 8'd0, 1'b0));
        #1 strobe = 1'b1;
        #1 strobe = 1'b0;
    endtask

    task automatic release_reset();
        @(negedge clk);
        #2 rst = 1'b1;
    endtask

    initial begin
        async_reset();

        // x held high: full 38-cycle rotation, CG forced at max, then the
        // next HG lasts 10 cycles; async reset mid-CG.
        release_reset();
        seg(1, 0, 0,  9, 1, 1, 0);
        seg(1, 0, 1,  3, 0, 1, 0);
        seg(1, 0, 2,  1, 0, 1, 0);
        seg(1, 0, 3, 20, 0, 1, 0);
        seg(1, 0, 4,  3, 0, 1, 0);
        seg(1, 0, 5,  1, 0, 1, 0);
        seg(1, 0, 0, 10, 0, 1, 0);
        seg(1, 0, 1,  3, 0, 1, 0);
        seg(1, 0, 2,  1, 0, 1, 0);
        seg(1, 0, 3,  6, 0, 1, 0);
        async_reset();

        // x low, pb pulse in cycle 2: request latched, min CG of 5, cleared
        // at CG entry; then idle HG saturates tmr at 255; x=1 -> HY next edge.
        release_reset();
        seg(0, 0, 0,   2,   1, 1, 0);
        seg(0, 1, 0,   1,   3, 1, 1);
        seg(0, 0, 0,   6,   4, 1, 1);
        seg(0, 0, 1,   3,   0, 1, 1);
        seg(0, 0, 2,   1,   0, 1, 1);
        seg(0, 0, 3,   5,   0, 1, 0);
        seg(0, 0, 4,   3,   0, 1, 0);
        seg(0, 0, 5,   1,   0, 1, 0);
        seg(0, 0, 0, 256,   0, 1, 0);
        seg(0, 0, 0,  44, 255, 0, 0);
        seg(1, 0, 1,   1,   0, 1, 0);
        async_reset();

        // x drops at CG tmr=2 -> 5-cycle CG; next round x drops at tmr=8
        // -> 9-cycle CG.
        release_reset();
        seg(1, 0, 0,  9, 1, 1, 0);
        seg(1, 0, 1,  3, 0, 1, 0);
        seg(1, 0, 2,  1, 0, 1, 0);
        seg(1, 0, 3,  3, 0, 1, 0);
        seg(0, 0, 3,  2, 3, 1, 0);
        seg(0, 0, 4,  3, 0, 1, 0);
        seg(0, 0, 5,  1, 0, 1, 0);
        seg(1, 0, 0, 10, 0, 1, 0);
        seg(1, 0, 1,  3, 0, 1, 0);
        seg(1, 0, 2,  1, 0, 1, 0);
        seg(1, 0, 3,  9, 0, 1, 0);
        seg(0, 0, 4,  3, 0, 1, 0);
        seg(0, 0, 5,  1, 0, 1, 0);
        seg(0, 0, 0,  1, 0, 1, 0);

        // pb on the AR1->CG edge and mid-CG: no request latched, so HG holds.
        seg(1, 0, 0,  9, 1, 1, 0);
        seg(1, 0, 1,  1, 0, 1, 0);
        seg(0, 0, 1,  2, 1, 1, 0);
        seg(0, 0, 2,  1, 0, 1, 0);
        seg(0, 1, 3,  1, 0, 1, 0);
        seg(0, 0, 3,  2, 1, 1, 0);
        seg(0, 1, 3,  1, 3, 1, 0);
        seg(0, 0, 3,  1, 4, 1, 0);
        seg(0, 0, 4,  3, 0, 1, 0);
        seg(0, 0, 5,  1, 0, 1, 0);
        seg(0, 0, 0, 40, 0, 1, 0);

        repeat (3) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d expected entries left unchecked, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tlc_timed.md
# tlc_timed

Parametrised second-generation highway/country traffic light controller with per-phase durations, all-red clearance intervals, a minimum and maximum country green, a latched pedestrian request and a free-running phase timer. It drives the same 2-bit lamp encoding as the existing `tlc` block and replaces it where configurable timing is required. All timing is in `clk` cycles.

## Interface
- `TW`, 8: phase timer width in bits.
- `T_HW_MIN`, 10: minimum highway green dwell, in cycles.
- `T_YEL`, 3: yellow duration, used for both roads.
- `T_ALLRED`, 1: all-red clearance duration, inserted after each yellow.
- `T_CR_MIN`, 5: minimum country green dwell.
- `T_CR_MAX`, 20: maximum country green dwell; the transition is forced even if `x` is still high.
- Legal parameter values: every duration ≥ 1, `T_CR_MAX ≥ T_CR_MIN`, every duration ≤ 2^TW−1. Illegal values are a configuration error and are not checked in RTL.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `x` in 1: country-road vehicle sensor, level-sensitive, synchronous to `clk`.
- `pb` in 1: pedestrian button, synchronous to `clk`; a pulse of any length is sufficient.
- `highway` out 2: highway lamp, 00 red, 01 yellow, 10 green.
- `country` out 2: country lamp, same encoding.
- `pedestrian_light` out 1: 1 = walk, 0 = stop.
- `ped_req` out 1: latched pedestrian request, waiting to be served.
- `phase` out 3: current state encoding, for debug and monitoring.
- `tmr` out TW: cycles spent in the current phase.

## Operation
- The state machine has six states, encoded in `phase`: HG=0, HY=1, AR1=2, CG=3, CY=4, AR2=5. Codes 6 and 7 go to HG on the next edge.
- Moore outputs decoded from the state:
  - HG: highway 10, country 00.
  - HY: highway 01, country 00.
  - AR1 and AR2: highway 00, country 00.
  - CG: highway 00, country 10, pedestrian_light 1.
  - CY: highway 00, country 01.
  - pedestrian_light is 0 in every state other than CG.
- `tmr` clears to 0 on the edge that changes state. Otherwise it increments by 1 per cycle and saturates at 2^TW−1 with no wrap.
- Transitions, evaluated on each rising edge:
  - HG→HY when `tmr ≥ T_HW_MIN−1` and (`x` or `ped_req`).
  - HY→AR1 when `tmr == T_YEL−1`.
  - AR1→CG when `tmr == T_ALLRED−1`.
  - CG→CY when (`tmr ≥ T_CR_MIN−1` and `!x`) or `tmr == T_CR_MAX−1`.
  - CY→AR2 when `tmr == T_YEL−1`.
  - AR2→HG when `tmr == T_ALLRED−1`.
- `ped_req` next value = (`ped_req` or (`pb` and state≠CG)) and not (AR1→CG transition this edge).
  - A `pb` press during CG is ignored, because walk is already lit.
  - A `pb` press on the AR1→CG edge is absorbed: the clear wins.
- `pb` does not extend CG; the pedestrian is served by the minimum green.

## Timing
- Reset (asynchronous, `rst`=0) takes effect immediately without a clock edge:
  - state HG, `tmr`=0, `ped_req`=0.
  - highway 10, country 00, pedestrian_light 0, phase 0.
- Release from reset is synchronous: the first state update is on the first rising edge with `rst`=1.
- A condition sampled at edge k changes the state at edge k; outputs reflect the new state after edge k, with no extra pipeline stage.
- Exact dwell times:
  - HY and CY: exactly `T_YEL` cycles.
  - AR1 and AR2: exactly `T_ALLRED` cycles.
  - CG: between `T_CR_MIN` and `T_CR_MAX` cycles.
  - HG: at least `T_HW_MIN` cycles.
- Full cycle with `x` held high and default parameters: 10+3+1+20+3+1 = 38 cycles.
- `x` and `pb` are not synchronised internally; synchronisers sit upstream.

## Test plan
- Release reset with `x`=1 held, defaults: HG 10 cycles → HY 3 → AR1 1 → CG 20 (forced at max) → CY 3 → AR2 1 → HG; the next HG lasts exactly 10 cycles.
- `x`=0, 1-cycle `pb` pulse at cycle 2: `ped_req`=1 from cycle 3; HY entered after cycle 10; CG lasts exactly 5 cycles with pedestrian_light=1; `ped_req`=0 from CG entry.
- `x`=1 into CG, then deasserted at CG `tmr`=2: CG exits at `tmr`=4 (5 cycles). If deasserted at `tmr`=8 instead: exit on the next edge, giving a 9-cycle CG.
- `pb` asserted on the AR1→CG edge and again mid-CG, `x`=0 afterwards: `ped_req` stays 0; after AR2 the controller remains in HG indefinitely.
- `rst` pulled low asynchronously mid-CG, between edges: outputs are immediately highway 10, country 00, pedestrian_light 0, `ped_req` 0, `tmr` 0.
- Idle HG for 300 cycles with TW=8: `tmr` saturates at 255. Then `x`=1: HY on the next edge.
